// File: rtl/address_buff_ctrl_if.sv
// address_buff_ctrl_if: fill/drain handshake and SRAM port bundle for the banked address buffer
interface address_buff_ctrl_if #(
  parameter int SRAM_DEPTH = 1024,
  parameter int BAND_WIDTH = 16
);
  localparam int AW = $clog2(SRAM_DEPTH);
  localparam int BW = $clog2(BAND_WIDTH);
  logic                           clear;
  logic                           rd_start;
  logic [BAND_WIDTH-1:0]          wr_valid;
  logic [BAND_WIDTH-1:0]          wea;
  logic [BAND_WIDTH-1:0][AW-1:0]  addra;
  logic                           enb;
  logic [BW+AW-1:0]               addrb;
  logic                           rd_valid;
  logic                           rd_last;
  logic                           busy;
  logic                           done;
  logic                           overflow;
  modport slave (
    input  clear, rd_start, wr_valid,
    output wea, addra, enb, addrb, rd_valid, rd_last, busy, done, overflow
  );
  modport master (
    output clear, rd_start, wr_valid,
    input  wea, addra, enb, addrb, rd_valid, rd_last, busy, done, overflow
  );
endinterface

// File: rtl/address_buff_ctrl.sv
// address_buff_ctrl: per-lane fill pointers into SRAM banks, then an in-order sweep of all banks through one read port
module address_buff_ctrl #(
  parameter int SRAM_DEPTH = 1024,
  parameter int BAND_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  address_buff_ctrl_if.slave bus
);
  localparam int AW = $clog2(SRAM_DEPTH);
  localparam int BW = $clog2(BAND_WIDTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {FILL, DRAIN, FLUSH} state_t;
  state_t                        state_q, state_d;
  logic [BAND_WIDTH-1:0][CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [BW-1:0]                 rd_bank_q, rd_bank_d;
  logic [CW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic                          rd_valid_q, rd_valid_d;
  logic                          rd_last_q, rd_last_d;
  logic                          done_q, done_d;
  logic                          overflow_q, overflow_d;
  logic [CW-1:0]                 cur_cnt;
  logic                          bank_end, rest_empty;
  always_comb begin
    cur_cnt    = wr_ptr_q[rd_bank_q];
    rest_empty = 1'b1;
    for (int j = 0; j < BAND_WIDTH; j++)
      if (j > int'(rd_bank_q) && wr_ptr_q[j] != '0) rest_empty = 1'b0;
    bus.enb   = state_q == DRAIN && rd_ptr_q < cur_cnt;
    bus.addrb = bus.enb ? {rd_bank_q, rd_ptr_q[AW-1:0]} : '0;
    bank_end  = state_q == DRAIN && (cur_cnt == '0 || rd_ptr_q + 1'b1 == cur_cnt);
    // Writes land in the same cycle; a full bank or a non-FILL state drops the word.
    for (int i = 0; i < BAND_WIDTH; i++) begin
      bus.wea[i]   = !rst && !bus.clear && state_q == FILL && bus.wr_valid[i] && wr_ptr_q[i] != CW'(SRAM_DEPTH);
      bus.addra[i] = wr_ptr_q[i][AW-1:0];
      wr_ptr_d[i]  = wr_ptr_q[i] + CW'(bus.wea[i]);
    end
    overflow_d = overflow_q | (|(bus.wr_valid & ~bus.wea));
    rd_valid_d = bus.enb;
    rd_last_d  = bus.enb && bank_end && rest_empty;
    state_d    = state_q;
    rd_bank_d  = rd_bank_q;
    rd_ptr_d   = rd_ptr_q;
    done_d     = 1'b0;
    if (state_q == FILL && bus.rd_start) begin
      state_d   = DRAIN;
      rd_bank_d = '0;
      rd_ptr_d  = '0;
    end
    if (state_q == DRAIN) begin
      rd_ptr_d  = bank_end ? '0 : rd_ptr_q + CW'(bus.enb);
      rd_bank_d = bank_end ? rd_bank_q + 1'b1 : rd_bank_q;
      state_d   = bank_end && rd_bank_q == BW'(BAND_WIDTH - 1) ? FLUSH : DRAIN;
    end
    if (state_q == FLUSH) begin
      state_d  = FILL;
      done_d   = 1'b1;
      wr_ptr_d = '0;
    end
    if (bus.clear) begin
      state_d    = FILL;
      wr_ptr_d   = '0;
      rd_bank_d  = '0;
      rd_ptr_d   = '0;
      done_d     = 1'b0;
      overflow_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      rd_bank_q  <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_bank_q  <= rd_bank_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = state_q != FILL;
endmodule

// File: tb/tb_address_buff_ctrl.sv
// tb_address_buff_ctrl: directed fill/drain scenarios with a read-order scoreboard
module tb_address_buff_ctrl;
  localparam int D  = 1024;
  localparam int N  = 16;
  localparam int AW = 10;
  typedef struct packed {logic [13:0] a; logic l;} rd_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  address_buff_ctrl_if #(.SRAM_DEPTH(D), .BAND_WIDTH(N)) bus ();
  address_buff_ctrl #(.SRAM_DEPTH(D), .BAND_WIDTH(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  rd_t         exp_q[$];
  rd_t         e;
  int          total = 0, bad = 0, done_cnt = 0, busy_cnt = 0, enb_cnt = 0;
  int          model[N];
  int          d0;
  logic [13:0] pend_a = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) done_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.enb) enb_cnt++;
      if (bus.rd_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected got addr=%h last=%b need none", pend_a, bus.rd_last);
        end else begin
          e = exp_q.pop_front();
          if ({pend_a, bus.rd_last} !== e) begin
            bad++;
            $display("FAIL rd_word got addr=%h last=%b need addr=%h last=%b", pend_a, bus.rd_last, e.a, e.l);
          end
        end
      end
      pend_a = bus.addrb;
    end
  end
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h need=%0h", nm, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(logic [N-1:0] m);
    bus.wr_valid = m;
    tick();
    bus.wr_valid = '0;
    for (int i = 0; i < N; i++) model[i] += int'(m[i]);
  endtask
  task automatic start_drain;
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
  endtask
  task automatic push_sweep;
    int c[N];
    int lb = -1;
    for (int b = 0; b < N; b++) begin
      c[b] = model[b] > D ? D : model[b];
      if (c[b] > 0) lb = b;
    end
    for (int b = 0; b < N; b++)
      for (int k = 0; k < c[b]; k++)
        exp_q.push_back('{a: 14'(b * D + k), l: (b == lb && k == c[b] - 1)});
    for (int b = 0; b < N; b++) model[b] = 0;
  endtask
  task automatic wait_done(int max);
    bit seen = 1'b0;
    for (int c = 0; c < max && !seen; c++) begin
      @(negedge clk);
      seen = bus.done;
    end
    chk("done_seen", 32'(seen), 1);
    tick();
  endtask
  initial begin
    for (int i = 0; i < N; i++) model[i] = 0;
    bus.wr_valid = '0;
    bus.rd_start = 1'b0;
    bus.clear    = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_enb", 32'(bus.enb), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_wea", 32'(bus.wea), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    // lane0 x3, lane2 x2
    wr(16'h0005);
    wr(16'h0005);
    bus.wr_valid = 16'h0001;
    #1 chk("t1_addra0", 32'(bus.addra[0]), 2);
    chk("t1_addra2", 32'(bus.addra[2]), 2);
    chk("t1_wea", 32'(bus.wea), 1);
    tick();
    bus.wr_valid = '0;
    for (int i = 0; i < N; i++) model[i] = 0;
    exp_q.push_back('{a: 14'h000, l: 1'b0});
    exp_q.push_back('{a: 14'h001, l: 1'b0});
    exp_q.push_back('{a: 14'h002, l: 1'b0});
    exp_q.push_back('{a: 14'h800, l: 1'b0});
    exp_q.push_back('{a: 14'h801, l: 1'b1});
    busy_cnt = 0;
    d0 = done_cnt;
    start_drain();
    chk("t1_enb_first", 32'(bus.enb), 1);
    wait_done(40);
    chk("t1_busy_cycles", 32'(busy_cnt), 20);
    chk("t1_done_once", 32'(done_cnt - d0), 1);
    chk("t1_queue_empty", 32'(exp_q.size()), 0);
    // all lanes in one cycle
    bus.wr_valid = '1;
    #1 chk("t2_wea", 32'(bus.wea), 32'hFFFF);
    chk("t2_addra_zero", 32'(bus.addra == '0), 1);
    tick();
    bus.wr_valid = '0;
    for (int i = 0; i < N; i++) model[i] = 1;
    push_sweep();
    busy_cnt = 0;
    enb_cnt  = 0;
    start_drain();
    wait_done(40);
    chk("t2_enb_cycles", 32'(enb_cnt), 16);
    chk("t2_busy_cycles", 32'(busy_cnt), 17);
    chk("t2_queue_empty", 32'(exp_q.size()), 0);
    // lane5 overfill
    bus.wr_valid = 16'h0020;
    repeat (1024) tick();
    chk("t3_ovf_before", 32'(bus.overflow), 0);
    chk("t3_wea_full", 32'(bus.wea), 0);
    tick();
    bus.wr_valid = '0;
    chk("t3_ovf_set", 32'(bus.overflow), 1);
    model[5] = 1025;
    push_sweep();
    start_drain();
    wait_done(1100);
    chk("t3_ovf_sticky", 32'(bus.overflow), 1);
    chk("t3_queue_empty", 32'(exp_q.size()), 0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("t3_ovf_cleared", 32'(bus.overflow), 0);
    // empty drain
    busy_cnt = 0;
    enb_cnt  = 0;
    d0       = done_cnt;
    start_drain();
    wait_done(40);
    chk("t4_busy_cycles", 32'(busy_cnt), 17);
    chk("t4_enb_cycles", 32'(enb_cnt), 0);
    chk("t4_done_once", 32'(done_cnt - d0), 1);
    // write arriving during drain
    wr(16'h0002);
    wr(16'h0082);
    push_sweep();
    start_drain();
    bus.wr_valid = 16'h0008;
    #1 chk("t5_wea_drain", 32'(bus.wea), 0);
    tick();
    bus.wr_valid = '0;
    chk("t5_ovf", 32'(bus.overflow), 1);
    wait_done(40);
    chk("t5_queue_empty", 32'(exp_q.size()), 0);
    // clear mid-drain
    repeat (10) wr(16'h0001);
    for (int i = 0; i < N; i++) model[i] = 0;
    for (int k = 0; k < 4; k++) exp_q.push_back('{a: 14'(k), l: 1'b0});
    d0 = done_cnt;
    start_drain();
    repeat (3) tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("t6_enb_after_clear", 32'(bus.enb), 0);
    chk("t6_busy_after_clear", 32'(bus.busy), 0);
    repeat (25) tick();
    chk("t6_no_done", 32'(done_cnt - d0), 0);
    chk("t6_queue_empty", 32'(exp_q.size()), 0);
    bus.wr_valid = 16'h0001;
    #1 chk("t6_ptr_zero", 32'(bus.addra[0]), 0);
    bus.wr_valid = '0;
    tick();
    // async reset mid-drain
    repeat (3) wr(16'h0001);
    for (int i = 0; i < N; i++) model[i] = 0;
    start_drain();
    tick();
    rst = 1'b1;
    #1 chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_enb", 32'(bus.enb), 0);
    chk("t6_rst_valid", 32'(bus.rd_valid), 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
